// File: rtl/mic_i2s_pkg.sv
// Shared frame geometry and channel numbering for the multi-microphone I2S receiver.
// Pure constants and a helper function; no logic, no latency.
// No flow control involved.
package mic_i2s_pkg;

  // One I2S frame is 64 SCK periods, split into a left and a right slot.
  localparam int frame_bits = 64;
  localparam int slot_bits  = 32;
  // The first SCK after a ws edge carries no data; the MSB follows it.
  localparam int msb_offset = 1;

  // Channel numbering: line-major, left slot before right slot.
  function automatic int chan_idx(input int line, input int slot);
    return 2 * line + slot;
  endfunction

endpackage

// File: rtl/mic_i2s_clk_gen.sv
// I2S bit clock / word select generator with rise and fall strobes and frame bit counter.
// Strobes are registered and high in the same clk cycle as the matching sck edge.
// Free-running; there is no backpressure.
module mic_i2s_clk_gen
  import mic_i2s_pkg::*;
#(
  parameter int sck_div = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sck,
  output logic       ws,
  output logic       rise_stb,
  output logic       fall_stb,
  output logic [5:0] bit_cnt
);

  localparam int div_w = (sck_div > 2) ? $clog2(sck_div) : 1;

  logic [div_w-1:0] div_cnt;
  logic             half_done;

  assign half_done = (div_cnt == div_w'(sck_div - 1));

  // Divide clk down to sck; bit_cnt advances on every sck falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      sck      <= 1'b0;
      bit_cnt  <= '0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      rise_stb <= half_done && !sck;
      fall_stb <= half_done && sck;
      if (half_done) begin
        div_cnt <= '0;
        sck     <= ~sck;
        if (sck) begin
          bit_cnt <= (bit_cnt == 6'(frame_bits - 1)) ? 6'd0 : bit_cnt + 6'd1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // ws is the slot half of the frame counter, so it only moves with a falling edge
  assign ws = bit_cnt[5];

endmodule

// File: rtl/multi_mic_i2s_receiver.sv
// Multi-line I2S microphone receiver: 2*n_mics channels captured per 64-bit frame, latched together.
// value/valid update 1 clk after the frame-wrap sck fall; first valid 128*sck_div+1 cycles after reset.
// No backpressure: valid is a one-cycle pulse per frame. Optional peak meter under MULTI_MIC_PEAK_EN.
module multi_mic_i2s_receiver
  import mic_i2s_pkg::*;
#(
  parameter int n_mics      = 2,
  parameter int w_sample    = 24,
  parameter int sck_div     = 4,
  parameter int decay_shift = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           sck,
  output logic                           ws,
  input  logic [n_mics-1:0]              sd,
  output logic [2*n_mics*w_sample-1:0]   value,
  output logic                           valid,
  output logic [2*n_mics*w_sample-1:0]   peak
);

  localparam int n_ch = 2 * n_mics;

  logic                rise_stb;
  logic                fall_stb;
  logic [5:0]          bit_cnt;
  logic [n_mics-1:0]   sd_meta;
  logic [n_mics-1:0]   sd_sync;
  logic [w_sample-1:0] shadow [n_ch];
  logic                slot;
  logic [4:0]          slot_pos;
  logic                capture;
  logic                frame_done;

  mic_i2s_clk_gen #(
    .sck_div (sck_div)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .ws       (ws),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .bit_cnt  (bit_cnt)
  );

  assign slot     = bit_cnt[5];
  assign slot_pos = bit_cnt[4:0];
  // Only slot bits msb_offset .. msb_offset+w_sample-1 carry the captured word.
  assign capture  = rise_stb
                 && ({1'b0, slot_pos} >= 6'(msb_offset))
                 && ({1'b0, slot_pos} <  6'(msb_offset + w_sample));
  // bit_cnt has just wrapped 63->0 on this falling edge.
  assign frame_done = fall_stb && (bit_cnt == 6'd0);

  // Two-flop synchroniser for the asynchronous data lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_meta <= '0;
      sd_sync <= '0;
    end else begin
      sd_meta <= sd;
      sd_sync <= sd_meta;
    end
  end

  // Shift each line's bit, MSB first, into the shadow of the slot currently on the wire
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < n_ch; k++) shadow[k] <= '0;
    end else if (capture) begin
      for (int l = 0; l < n_mics; l++) begin
        for (int s = 0; s < 2; s++) begin
          if (slot == s[0]) begin
            shadow[chan_idx(l, s)] <= {shadow[chan_idx(l, s)][w_sample-2:0], sd_sync[l]};
          end
        end
      end
    end
  end

  // Commit every shadow to the output together so consumers never see a partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      valid <= 1'b0;
    end else begin
      valid <= frame_done;
      if (frame_done) begin
        for (int k = 0; k < n_ch; k++) value[k*w_sample +: w_sample] <= shadow[k];
      end
    end
  end

`ifdef MULTI_MIC_PEAK_EN
  // Magnitude of a signed sample; the most negative code saturates to the largest positive one.
  function automatic logic [w_sample-1:0] mag_sat(input logic [w_sample-1:0] x);
    if (x == {1'b1, {(w_sample-1){1'b0}}}) return {1'b0, {(w_sample-1){1'b1}}};
    if (x[w_sample-1]) return ~x + 1'b1;
    return x;
  endfunction

  for (genvar k = 0; k < n_ch; k++) begin : g_peak
    logic [w_sample-1:0] pk;
    logic [w_sample-1:0] mag;
    logic [w_sample-1:0] decayed;

    assign mag     = mag_sat(shadow[k]);
    assign decayed = pk - (pk >> decay_shift);
    assign peak[k*w_sample +: w_sample] = pk;

    // Peak jumps to a larger magnitude, otherwise decays geometrically once per frame
    always_ff @(posedge clk) begin
      if (rst) begin
        pk <= '0;
      end else if (frame_done) begin
        pk <= (mag > decayed) ? mag : decayed;
      end
    end
  end
`else
  assign peak = '0;
`endif

endmodule
